// File: rtl/riscv_pkg.sv
// Shared types for the RV32IM execute stage: operation encodings, forwarding
// selects and the iterative mul/div engine state.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } ex_op_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic { MD_IDLE, MD_BUSY } md_state_t;

  function automatic logic is_md_op(input ex_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M engine: shift-add multiply / restoring divide on operand
// magnitudes, one step per cycle, with the sign fix-up folded into the last step.
module muldiv_iter #(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int MD_STEPS = riscv_pkg::XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  riscv_pkg::ex_op_t op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result
);
  import riscv_pkg::*;

  localparam int CW = $clog2(MD_STEPS);
  localparam logic [CW-1:0] LAST = CW'(MD_STEPS - 1);

  md_state_t         state, state_next;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc, acc_next, prod_fix;
  logic [XLEN-1:0]   opnd, a_mag, b_mag, sel;
  logic              is_div, want_high, want_rem, neg_res;
  logic              a_signed, b_signed, a_neg, b_neg, st_div, st_high, st_rem;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    st_div   = 1'b0;
    st_high  = 1'b0;
    st_rem   = 1'b0;
    case (op)
      OP_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; st_high = 1'b1; end
      OP_MULHSU: begin a_signed = 1'b1; st_high = 1'b1; end
      OP_MULHU:  st_high = 1'b1;
      OP_DIV:    begin a_signed = 1'b1; b_signed = 1'b1; st_div = 1'b1; end
      OP_DIVU:   st_div = 1'b1;
      OP_REM:    begin a_signed = 1'b1; b_signed = 1'b1; st_div = 1'b1; st_rem = 1'b1; end
      OP_REMU:   begin st_div = 1'b1; st_rem = 1'b1; end
      default:   ;
    endcase
    a_neg = a_signed && a[XLEN-1];
    b_neg = b_signed && b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start && !flush) state_next = MD_BUSY;
      MD_BUSY: if (flush || count == LAST) state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MD_BUSY);
    done = (state == MD_BUSY) && (count == LAST);
  end

  // Multiply keeps the multiplier in acc's low half; divide keeps the dividend there.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      acc       <= '0;
      opnd      <= '0;
      is_div    <= 1'b0;
      want_high <= 1'b0;
      want_rem  <= 1'b0;
      neg_res   <= 1'b0;
    end else if (flush) begin
      count <= '0;
    end else if (start && state == MD_IDLE) begin
      count     <= '0;
      is_div    <= st_div;
      want_high <= st_high;
      want_rem  <= st_rem;
      neg_res   <= st_rem ? a_neg : (a_neg ^ b_neg);
      acc       <= {{XLEN{1'b0}}, st_div ? a_mag : b_mag};
      opnd      <= st_div ? b_mag : a_mag;
    end else if (state == MD_BUSY) begin
      count <= count + 1'b1;
      acc   <= acc_next;
    end
  end

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div) begin
      if (div_diff[XLEN]) acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else                acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_res ? -acc_next : acc_next;
    sel      = want_rem ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    if (is_div)         result = neg_res ? -sel : sel;
    else if (want_high) result = prod_fix[2*XLEN-1:XLEN];
    else                result = prod_fix[XLEN-1:0];
  end

endmodule

// File: rtl/ex_stage.sv
// RISC-V execute stage: bypass muxes, single-cycle ALU, iterative M-extension
// engine and a valid/ready output register feeding EX/MEM.
module ex_stage #(
  parameter int XLEN     = 32,
  parameter int MD_STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alu_src_b,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_reg_write,
  input  logic            in_mem_write,
  input  logic [1:0]      forward_a,
  input  logic [1:0]      forward_b,
  input  logic [XLEN-1:0] ex_mem_fwd_data,
  input  logic [XLEN-1:0] mem_wb_fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd_addr,
  output logic            out_reg_write,
  output logic            out_mem_write
);
  import riscv_pkg::*;

  localparam int SHW = $clog2(XLEN);

  ex_op_t          op;
  logic [XLEN-1:0] op_a, rs2_fwd, op_b, imm_result, md_result;
  logic [XLEN-1:0] pend_store;
  logic [4:0]      pend_rd;
  logic            pend_rw, pend_mw;
  logic            accept, div_family, div_zero, div_ovf, md_start, md_busy, md_done;

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb);
    case (sel)
      FWD_MEM: return mem;
      FWD_WB:  return wb;
      default: return rf;
    endcase
  endfunction

  assign op       = ex_op_t'(in_op);
  assign op_a     = fwd_mux(forward_a, in_rs1_data, ex_mem_fwd_data, mem_wb_fwd_data);
  assign rs2_fwd  = fwd_mux(forward_b, in_rs2_data, ex_mem_fwd_data, mem_wb_fwd_data);
  assign op_b     = in_alu_src_b ? in_imm : rs2_fwd;
  assign in_ready = !rst && !md_busy && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Divide-by-zero and signed overflow finish in one cycle without the engine.
  assign div_family = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign div_zero   = div_family && (op_b == '0);
  assign div_ovf    = (op == OP_DIV || op == OP_REM) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign md_start   = accept && is_md_op(op) && !div_zero && !div_ovf;

  always_comb begin
    imm_result = '0;
    case (op)
      OP_ADD:  imm_result = op_a + op_b;
      OP_SUB:  imm_result = op_a - op_b;
      OP_SLL:  imm_result = op_a << op_b[SHW-1:0];
      OP_SLT:  imm_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: imm_result = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:  imm_result = op_a ^ op_b;
      OP_SRL:  imm_result = op_a >> op_b[SHW-1:0];
      OP_SRA:  imm_result = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
      OP_OR:   imm_result = op_a | op_b;
      OP_AND:  imm_result = op_a & op_b;
      OP_DIV, OP_DIVU: imm_result = div_zero ? '1 : op_a;
      OP_REM, OP_REMU: imm_result = div_zero ? op_a : '0;
      default: imm_result = '0;
    endcase
  end

  muldiv_iter #(.XLEN(XLEN), .MD_STEPS(MD_STEPS)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (md_start),
    .op     (op),
    .a      (op_a),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_store <= '0;
      pend_rd    <= '0;
      pend_rw    <= 1'b0;
      pend_mw    <= 1'b0;
    end else if (md_start) begin
      pend_store <= rs2_fwd;
      pend_rd    <= in_rd_addr;
      pend_rw    <= in_reg_write;
      pend_mw    <= in_mem_write;
    end
  end

  // Flush outranks both engine completion and a fresh single-cycle result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_store_data <= '0;
      out_rd_addr    <= '0;
      out_reg_write  <= 1'b0;
      out_mem_write  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (md_done) begin
      out_valid      <= 1'b1;
      out_result     <= md_result;
      out_store_data <= pend_store;
      out_rd_addr    <= pend_rd;
      out_reg_write  <= pend_rw;
      out_mem_write  <= pend_mw;
    end else if (accept && !md_start) begin
      out_valid      <= 1'b1;
      out_result     <= imm_result;
      out_store_data <= rs2_fwd;
      out_rd_addr    <= in_rd_addr;
      out_reg_write  <= in_reg_write;
      out_mem_write  <= in_mem_write;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: forwarding, ALU ops, iterative mul/div,
// special divides, backpressure, back-to-back issue, flush and reset aborts.
module tb_ex_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_alu_src_b;
  logic [4:0]  in_op, in_rd_addr, out_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, ex_mem_fwd_data, mem_wb_fwd_data;
  logic        in_reg_write, in_mem_write, out_valid, out_ready, out_reg_write, out_mem_write;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] out_result, out_store_data;

  int total = 0;
  int bad   = 0;

  ex_stage #(.XLEN(32), .MD_STEPS(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alu_src_b(in_alu_src_b), .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .in_mem_write(in_mem_write), .forward_a(forward_a), .forward_b(forward_b),
    .ex_mem_fwd_data(ex_mem_fwd_data), .mem_wb_fwd_data(mem_wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_op = OP_ADD; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_alu_src_b = 0; in_rd_addr = 0; in_reg_write = 0; in_mem_write = 0;
    forward_a = FWD_NONE; forward_b = FWD_NONE; ex_mem_fwd_data = 0; mem_wb_fwd_data = 0;
    out_ready = 1;
  endtask

  task automatic drive(input ex_op_t op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic src_b, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [4:0] rd, input logic rw, input logic mw);
    in_valid = 1; in_op = op; in_rs1_data = rs1; in_rs2_data = rs2; in_imm = imm;
    in_alu_src_b = src_b; forward_a = fa; forward_b = fb; in_rd_addr = rd;
    in_reg_write = rw; in_mem_write = mw;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    step(); step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_result !== 32'h0 || out_store_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_data: got %h/%h want 0/0", out_result, out_store_data); end
    total++; if (out_rd_addr !== 5'd0 || out_reg_write !== 1'b0 || out_mem_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_ctrl: got %0d/%b/%b want 0/0/0", out_rd_addr, out_reg_write, out_mem_write); end
    rst = 0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_in_ready: got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_add_fwd();
    drive(OP_ADD, 32'd99, 32'd7, 32'd0, 0, FWD_MEM, FWD_NONE, 5'd3, 1, 0);
    ex_mem_fwd_data = 32'd5; mem_wb_fwd_data = 32'd77; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL add_in_ready: got %b want 1", in_ready); end
    step(); in_valid = 0; ex_mem_fwd_data = 32'd0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL add_valid: got %b want 1", out_valid); end
    total++; if (out_result !== 32'd12) begin bad++; $display("[TB] FAIL add_result: got %h want %h", out_result, 32'd12); end
    total++; if (out_rd_addr !== 5'd3 || out_reg_write !== 1'b1 || out_store_data !== 32'd7) begin bad++; $display("[TB] FAIL add_passthru: got %0d/%b/%h want 3/1/7", out_rd_addr, out_reg_write, out_store_data); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_transfer: got %b want 0", out_valid); end
  endtask

  task automatic test_sub_fwd();
    drive(OP_SUB, 32'd1, 32'd100, 32'd0, 0, FWD_NONE, FWD_WB, 5'd4, 1, 1);
    mem_wb_fwd_data = 32'd3;
    step(); in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFE) begin bad++; $display("[TB] FAIL sub_result: got %b/%h want 1/fffffffe", out_valid, out_result); end
    total++; if (out_store_data !== 32'd3 || out_mem_write !== 1'b1) begin bad++; $display("[TB] FAIL sub_store: got %h/%b want 3/1", out_store_data, out_mem_write); end
    step();
  endtask

  task automatic test_alu_misc();
    ex_op_t      ops[11];
    logic [31:0] as[11], bs[11], exps[11];
    logic        srcb[11];
    logic [1:0]  fas[11];
    ops  = '{OP_SLL, OP_SRA, OP_SRL, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND, OP_ADD, OP_ADD, OP_SRA};
    as   = '{32'd1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
             32'hF0, 32'hFF00_FF00, 32'hFFFF_FFFF, 32'd10, 32'h8000_0000};
    bs   = '{32'h24, 32'd4, 32'd4, 32'd1, 32'd1, 32'h0FF0_0FF0, 32'h0F, 32'h0FF0_0FF0, 32'd2, 32'd5, 32'h21};
    exps = '{32'h10, 32'hF800_0000, 32'h0800_0000, 32'd1, 32'd0, 32'hFF00_FF00, 32'hFF,
             32'h0F00_0F00, 32'd1, 32'd15, 32'hC000_0000};
    srcb = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    fas  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
    ex_mem_fwd_data = 32'd1000; mem_wb_fwd_data = 32'd2000;
    for (int i = 0; i < 11; i++) begin
      drive(ops[i], as[i], srcb[i] ? 32'd999 : bs[i], srcb[i] ? bs[i] : 32'hDEAD_0001,
            srcb[i], fas[i], FWD_NONE, 5'd7, 1, 0);
      step();
      total++; if (out_valid !== 1'b1 || out_result !== exps[i]) begin bad++; $display("[TB] FAIL alu_vec%0d: got %b/%h want 1/%h", i, out_valid, out_result, exps[i]); end
    end
    in_valid = 0; step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(OP_ADD, 32'(3 * i), 32'd100, 32'd0, 0, FWD_NONE, FWD_NONE, 5'(i + 1), 1, 0);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
      step();
      total++; if (out_valid !== 1'b1 || out_result !== 32'(100 + 3 * i) || out_rd_addr !== 5'(i + 1)) begin bad++; $display("[TB] FAIL b2b_result%0d: got %b/%h/%0d want 1/%h/%0d", i, out_valid, out_result, out_rd_addr, 32'(100 + 3 * i), i + 1); end
    end
    in_valid = 0; step();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    drive(OP_ADD, 32'd1, 32'd1, 32'd0, 0, FWD_NONE, FWD_NONE, 5'd9, 1, 0);
    step();
    drive(OP_ADD, 32'd10, 32'd10, 32'd0, 0, FWD_NONE, FWD_NONE, 5'd10, 1, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (out_valid !== 1'b1 || out_result !== 32'd2 || out_rd_addr !== 5'd9) begin bad++; $display("[TB] FAIL bp_hold%0d: got %b/%h/%0d want 1/2/9", k, out_valid, out_result, out_rd_addr); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready%0d: got %b want 0", k, in_ready); end
      step();
    end
    out_ready = 1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready: got %b want 1", in_ready); end
    step(); in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_result !== 32'd20 || out_rd_addr !== 5'd10) begin bad++; $display("[TB] FAIL bp_next: got %b/%h/%0d want 1/14/10", out_valid, out_result, out_rd_addr); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_mulh();
    int busy_bad = 0;
    drive(OP_MULH, 32'd0, 32'h8000_0000, 32'd0, 0, FWD_MEM, FWD_NONE, 5'd12, 1, 0);
    ex_mem_fwd_data = 32'h8000_0000;
    step(); in_valid = 0; ex_mem_fwd_data = 32'd0;
    for (int k = 1; k <= 32; k++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
      step();
    end
    total++; if (busy_bad != 0) begin bad++; $display("[TB] FAIL mulh_busy: got %0d bad busy cycles want 0", busy_bad); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mulh_latency: got valid=%b at N+33 want 1", out_valid); end
    total++; if (out_result !== 32'h4000_0000 || out_rd_addr !== 5'd12) begin bad++; $display("[TB] FAIL mulh_result: got %h/%0d want 40000000/12", out_result, out_rd_addr); end
    step();
  endtask

  task automatic test_md_ops();
    ex_op_t      ops[9];
    logic [31:0] as[9], bs[9], exps[9];
    int          n;
    ops  = '{OP_MUL, OP_MULHU, OP_MULHSU, OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_REM, OP_DIV};
    as   = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
             32'd100, 32'd100, 32'd7, 32'h8000_0000};
    bs   = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'd2};
    exps = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
             32'd14, 32'd2, 32'd1, 32'hC000_0000};
    for (int i = 0; i < 9; i++) begin
      drive(ops[i], as[i], bs[i], 32'd0, 0, FWD_NONE, FWD_NONE, 5'd20, 1, 0);
      step(); in_valid = 0;
      n = 1;
      while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
      total++; if (n != 33) begin bad++; $display("[TB] FAIL md_latency%0d: got %0d want 33", i, n); end
      total++; if (out_result !== exps[i]) begin bad++; $display("[TB] FAIL md_result%0d: got %h want %h", i, out_result, exps[i]); end
      step();
    end
  endtask

  task automatic test_div_special();
    ex_op_t      ops[6];
    logic [31:0] as[6], bs[6], exps[6];
    ops  = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    as   = '{32'd7, 32'h8000_0000, 32'd7, 32'd9, 32'h8000_0000, 32'd5};
    bs   = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
    exps = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd9, 32'h8000_0000, 32'd5};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], as[i], bs[i], 32'd0, 0, FWD_NONE, FWD_NONE, 5'd21, 1, 0);
      step();
      total++; if (out_valid !== 1'b1 || out_result !== exps[i]) begin bad++; $display("[TB] FAIL divspec%0d: got %b/%h want 1/%h", i, out_valid, out_result, exps[i]); end
    end
    in_valid = 0; step();
  endtask

  task automatic test_flush_busy();
    logic seen = 1'b0;
    drive(OP_DIVU, 32'd100, 32'd7, 32'd0, 0, FWD_NONE, FWD_NONE, 5'd22, 1, 0);
    step(); in_valid = 0;
    repeat (10) step();
    flush = 1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_ready_during: got %b want 0", in_ready); end
    step(); flush = 0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_ready_after: got %b want 1", in_ready); end
    repeat (40) begin step(); if (out_valid === 1'b1) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("[TB] FAIL flush_no_result: got valid=1 want never"); end
    drive(OP_ADD, 32'd2, 32'd3, 32'd0, 0, FWD_NONE, FWD_NONE, 5'd5, 1, 0);
    step(); in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_result !== 32'd5) begin bad++; $display("[TB] FAIL flush_recover: got %b/%h want 1/5", out_valid, out_result); end
    step();
  endtask

  task automatic test_reset_busy();
    logic seen = 1'b0;
    drive(OP_MUL, 32'd6, 32'd7, 32'd0, 0, FWD_NONE, FWD_NONE, 5'd23, 1, 0);
    step(); in_valid = 0;
    repeat (10) step();
    rst = 1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rstbusy_ready_during: got %b want 0", in_ready); end
    step(); rst = 0; #1;
    total++; if (in_ready !== 1'b1 || out_result !== 32'd0) begin bad++; $display("[TB] FAIL rstbusy_after: got %b/%h want 1/0", in_ready, out_result); end
    repeat (40) begin step(); if (out_valid === 1'b1) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("[TB] FAIL rstbusy_no_result: got valid=1 want never"); end
  endtask

  initial begin
    test_reset();
    test_add_fwd();
    test_sub_fwd();
    test_alu_misc();
    test_back_to_back();
    test_backpressure();
    test_mulh();
    test_md_ops();
    test_div_special();
    test_flush_busy();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
